audio_stream_ctrl: RTL and testbench
====================================

AUDIO_STREAM_CTRL -- requirements
Module: audio_stream_ctrl

Interface
REQ-001 Parameter SAMPLE_W, default 16: bit width of each channel sample.
REQ-002 Parameter FIFO_DEPTH, default 8: sample-pair buffer depth; power of two, 2 to 64.
REQ-003 Clk  input  1  system clock; all state changes on its rising edge.
REQ-004 Reset_n  input  1  asynchronous active-low reset.
REQ-005 RUN  input  1  level; high enables streaming, low returns the block to idle.
REQ-006 INIT_FINISH  input  1  codec reports that initialisation is complete.
REQ-007 data_over  input  1  codec level; high while the current sample pair is latched or being shifted.
REQ-008 in_valid  input  1  producer offers a sample pair.
REQ-009 in_l, in_r  input  SAMPLE_W each  producer left and right samples, two's complement.
REQ-010 in_ready  output  1  FIFO can accept a pair.
REQ-011 INIT  output  1  requests codec initialisation.
REQ-012 LDATA, RDATA  output  SAMPLE_W each  samples presented to the codec.
REQ-013 fifo_level  output  $clog2(FIFO_DEPTH)+1  count of pairs held.
REQ-014 underrun_cnt  output  8  saturating count of consumed empty slots.
REQ-015 vol  input  4  attenuation shift; present only with AUDIO_VOLUME_EN.

Function
REQ-016 The FSM SHALL have states HOLD, START, WRITE and DONE.
REQ-017 HOLD->START when RUN=1; START->WRITE when INIT_FINISH=1; WRITE->DONE when data_over=1; DONE->WRITE when data_over=0.
REQ-018 RUN=0 in START, WRITE or DONE SHALL force HOLD on the next edge and flush the FIFO (count=0) on that edge; RUN=0 takes priority over every other transition.
REQ-019 INIT SHALL be 1 only in START.
REQ-020 LDATA and RDATA SHALL combinationally equal the FIFO head in WRITE when the FIFO is non-empty, and SHALL be 0 otherwise (including DONE and when empty).
REQ-021 Push: in_valid & in_ready writes {in_l,in_r} at the tail on the clock edge; pushes are accepted in every state except during the flush edge.
REQ-022 in_ready SHALL be (fifo_level != FIFO_DEPTH), derived from registered count only; a push offered while full is dropped and not stored.
REQ-023 Pop: the edge on which the FSM leaves WRITE for DONE advances the head by one if the FIFO is non-empty.
REQ-024 A pop with the FIFO empty SHALL increment underrun_cnt, saturating at 255; the count clears only on reset.
REQ-025 A push and a pop on the same edge SHALL leave fifo_level unchanged and keep both data items ordered correctly.
REQ-026 Read and write pointers SHALL wrap modulo FIFO_DEPTH; fifo_level SHALL range 0..FIFO_DEPTH.
REQ-027 Latency: a pair pushed into an empty FIFO while in WRITE SHALL appear on LDATA/RDATA in the cycle after the push edge.

Reset
REQ-028 Reset_n=0 SHALL asynchronously set state=HOLD, pointers=0, fifo_level=0, underrun_cnt=0; INIT=0, LDATA=RDATA=0, and in_ready=1.
REQ-029 Reset asserted mid-stream SHALL discard buffered data; after release the block waits in HOLD for RUN.

Configuration
REQ-030 Macro AUDIO_VOLUME_EN: when defined, the vol port exists, and LDATA and RDATA SHALL equal the selected sample arithmetically right-shifted by vol (sign-preserving; vol>=SAMPLE_W yields all sign bits).
REQ-031 When AUDIO_VOLUME_EN is undefined, there SHALL be no vol port and samples SHALL pass unmodified.

Verification
REQ-032 Reset, RUN=1, INIT_FINISH=1 after 5 cycles -> INIT high for exactly those START cycles, then WRITE with LDATA=RDATA=0 (empty).
REQ-033 In WRITE, push pairs (0x1234,0xABCD) and (0x0001,0xFFFF), then pulse data_over 1->0 twice -> outputs present each pair in order and fifo_level goes 2->1->0.
REQ-034 Push 8 pairs at the default depth -> in_ready=0 and fifo_level=8; a 9th push is dropped; a push and pop on the same edge when full -> level stays 8 after the following push.
REQ-035 Empty FIFO with 300 data_over pulses -> underrun_cnt saturates at 255 and LDATA=0 throughout.
REQ-036 RUN dropped in DONE with 3 pairs buffered -> HOLD next edge, fifo_level=0, INIT=0; asynchronous Reset_n pulse mid-WRITE -> all outputs reset immediately.
REQ-037 AUDIO_VOLUME_EN defined, vol=2, head 0x8000 -> LDATA=0xE000; vol=0 -> 0x8000.

Source files
------------

// File: rtl/audio_stream_ctrl_if.sv
// audio_stream_ctrl_if
// Producer-side sample-pair stream into audio_stream_ctrl.
//   in_valid : producer offers a left/right sample pair
//   in_l     : left sample, two's complement
//   in_r     : right sample, two's complement
//   in_ready : controller FIFO can accept a pair
// Modports: master (producer), slave (audio_stream_ctrl).
interface audio_stream_ctrl_if #(
    parameter int SAMPLE_W = 16
);
    logic                in_valid;
    logic [SAMPLE_W-1:0] in_l;
    logic [SAMPLE_W-1:0] in_r;
    logic                in_ready;

    modport master (
        output in_valid,
        output in_l,
        output in_r,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_l,
        input  in_r,
        output in_ready
    );
endinterface

// File: rtl/audio_stream_ctrl.sv
// audio_stream_ctrl
// Buffers left/right sample pairs from a producer and presents them to an
// audio codec, sequencing codec initialisation and the per-sample handshake.
// Ports:
//   Clk          : system clock, rising edge
//   Reset_n      : asynchronous active-low reset
//   RUN          : level, high enables streaming, low returns to idle
//   INIT_FINISH  : codec initialisation complete
//   data_over    : codec busy latching/shifting the current pair
//   stream       : producer stream (audio_stream_ctrl_if.slave)
//   vol          : attenuation shift (only with AUDIO_VOLUME_EN)
//   INIT         : codec initialisation request
//   LDATA, RDATA : samples presented to the codec
//   fifo_level   : number of pairs held
//   underrun_cnt : saturating count of pops taken from an empty FIFO
// Optional feature macro: AUDIO_VOLUME_EN (adds vol, arithmetic right shift).
module audio_stream_ctrl #(
    parameter int SAMPLE_W   = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          Clk,
    input  logic                          Reset_n,
    input  logic                          RUN,
    input  logic                          INIT_FINISH,
    input  logic                          data_over,
    audio_stream_ctrl_if.slave            stream,
`ifdef AUDIO_VOLUME_EN
    input  logic [3:0]                    vol,
`endif
    output logic                          INIT,
    output logic [SAMPLE_W-1:0]           LDATA,
    output logic [SAMPLE_W-1:0]           RDATA,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [7:0]                    underrun_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    typedef enum logic [1:0] {HOLD, START, WRITE, DONE} state_t;

    state_t state, state_next;

    logic [2*SAMPLE_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [AW:0]           count;
    logic                  flush, pop_edge, push, pop, underrun;
    logic [SAMPLE_W-1:0]   head_l, head_r;
    logic                  present;

    // RUN low outside HOLD returns to idle and discards the buffer.
    assign flush    = (state != HOLD) && !RUN;
    // The WRITE->DONE edge is the codec consuming the presented pair.
    assign pop_edge = (state == WRITE) && RUN && data_over;
    assign pop      = pop_edge && (count != '0);
    assign underrun = pop_edge && (count == '0);
    assign push     = stream.in_valid && stream.in_ready && !flush;

    assign stream.in_ready = (count != CNT_FULL);
    assign fifo_level      = count;

    // State register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= HOLD;
        else          state <= state_next;
    end

    // Next-state logic; RUN low dominates every other transition
    always_comb begin
        state_next = state;
        if (state != HOLD && !RUN) begin
            state_next = HOLD;
        end else begin
            case (state)
                HOLD:    if (RUN)         state_next = START;
                START:   if (INIT_FINISH) state_next = WRITE;
                WRITE:   if (data_over)   state_next = DONE;
                DONE:    if (!data_over)  state_next = WRITE;
                default:                  state_next = HOLD;
            endcase
        end
    end

    // Output logic
    assign head_l  = mem[rd_ptr][2*SAMPLE_W-1:SAMPLE_W];
    assign head_r  = mem[rd_ptr][SAMPLE_W-1:0];
    assign present = (state == WRITE) && (count != '0);

    always_comb begin
        INIT  = (state == START);
        LDATA = '0;
        RDATA = '0;
        if (present) begin
`ifdef AUDIO_VOLUME_EN
            LDATA = $signed(head_l) >>> vol;
            RDATA = $signed(head_r) >>> vol;
`else
            LDATA = head_l;
            RDATA = head_r;
`endif
        end
    end

    // FIFO storage; contents are only read while count is non-zero
    always_ff @(posedge Clk) begin
        if (push) mem[wr_ptr] <= {stream.in_l, stream.in_r};
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)                             underrun_cnt <= '0;
        else if (underrun && underrun_cnt != '1)  underrun_cnt <= underrun_cnt + 8'd1;
    end

endmodule

// File: tb/tb_audio_stream_ctrl.sv
// tb_audio_stream_ctrl
// Scoreboard bench for audio_stream_ctrl: stimulus pushes the expected pair
// for every accepted sample (and a zero pair for each empty consume) into a
// queue; a monitor compares LDATA/RDATA each time the codec raises data_over.
module tb_audio_stream_ctrl;

    localparam int W     = 16;
    localparam int DEPTH = 8;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        RUN;
    logic        INIT_FINISH;
    logic        data_over;
    logic        INIT;
    logic [W-1:0] LDATA, RDATA;
    logic [3:0]  fifo_level;
    logic [7:0]  underrun_cnt;
`ifdef AUDIO_VOLUME_EN
    logic [3:0]  vol;
`endif

    audio_stream_ctrl_if #(.SAMPLE_W(W)) s_if ();

    audio_stream_ctrl #(.SAMPLE_W(W), .FIFO_DEPTH(DEPTH)) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .RUN          (RUN),
        .INIT_FINISH  (INIT_FINISH),
        .data_over    (data_over),
        .stream       (s_if),
`ifdef AUDIO_VOLUME_EN
        .vol          (vol),
`endif
        .INIT         (INIT),
        .LDATA        (LDATA),
        .RDATA        (RDATA),
        .fifo_level   (fifo_level),
        .underrun_cnt (underrun_cnt)
    );

    always #5 Clk = ~Clk;

    int asserts = 0;
    int fails   = 0;
    logic [31:0] exp_q [$];
    int mcnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: the pair on LDATA/RDATA when data_over rises is what the codec takes
    initial begin : monitor
        logic [31:0] pair;
        forever begin
            @(posedge data_over);
            if (exp_q.size() == 0) begin
                asserts++;
                fails++;
                $display("FAIL monitor_unexpected: got %h/%h expected no output", LDATA, RDATA);
            end else begin
                pair = exp_q.pop_front();
                check("LDATA", {16'h0, LDATA}, {16'h0, pair[31:16]});
                check("RDATA", {16'h0, RDATA}, {16'h0, pair[15:0]});
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic push_x(input logic [15:0] l, input logic [15:0] r,
                          input logic [15:0] el, input logic [15:0] er);
        s_if.in_valid = 1'b1;
        s_if.in_l     = l;
        s_if.in_r     = r;
        if (mcnt < DEPTH) begin
            mcnt++;
            exp_q.push_back({el, er});
        end
        step();
        s_if.in_valid = 1'b0;
    endtask

    task automatic push_pair(input logic [15:0] l, input logic [15:0] r);
        push_x(l, r, l, r);
    endtask

    task automatic consume();
        if (mcnt == 0) exp_q.push_back(32'h0);
        else           mcnt--;
        data_over = 1'b1;
        step();
        data_over = 1'b0;
        step();
    endtask

    initial begin : stim
        Reset_n       = 1'b0;
        RUN           = 1'b0;
        INIT_FINISH   = 1'b0;
        data_over     = 1'b0;
        s_if.in_valid = 1'b0;
        s_if.in_l     = '0;
        s_if.in_r     = '0;
`ifdef AUDIO_VOLUME_EN
        vol = 4'd0;
`endif
        step();
        step();
        check("rst_level",    32'(fifo_level),   0);
        check("rst_in_ready", 32'(s_if.in_ready), 1);
        check("rst_INIT",     32'(INIT),         0);
        check("rst_LDATA",    32'(LDATA),        0);
        check("rst_underrun", 32'(underrun_cnt), 0);
        Reset_n = 1'b1;
        step();
        check("hold_INIT", 32'(INIT), 0);

        // Initialisation sequence: five START cycles
        RUN = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("start_INIT", 32'(INIT), 1);
        end
        INIT_FINISH = 1'b1;
        step();
        INIT_FINISH = 1'b0;
        check("write_INIT",  32'(INIT),  0);
        check("write_LDATA", 32'(LDATA), 0);
        check("write_RDATA", 32'(RDATA), 0);

        // Two pairs in order
        push_pair(16'h1234, 16'hABCD);
        push_pair(16'h0001, 16'hFFFF);
        check("level_2", 32'(fifo_level), 2);
        consume();
        check("level_1", 32'(fifo_level), 1);
        consume();
        check("level_0", 32'(fifo_level), 0);

        // Push into empty FIFO in WRITE is visible the following cycle
        push_pair(16'h5555, 16'hAAAA);
        check("latency_L", 32'(LDATA), 32'h5555);
        check("latency_R", 32'(RDATA), 32'hAAAA);
        consume();

`ifdef AUDIO_VOLUME_EN
        vol = 4'd2;
        push_x(16'h8000, 16'h4000, 16'hE000, 16'h1000);
        consume();
        vol = 4'd0;
        push_x(16'h8000, 16'h4000, 16'h8000, 16'h4000);
        consume();
`endif

        // Fill to full, drop a 9th push
        for (int i = 0; i < DEPTH; i++)
            push_pair(16'(16'h1000 + i), 16'(16'h2000 + i));
        check("full_level",    32'(fifo_level),    8);
        check("full_in_ready", 32'(s_if.in_ready), 0);
        push_pair(16'hDEAD, 16'hBEEF);
        check("drop_level", 32'(fifo_level), 8);

        // Push and pop on the same edge while full: push is dropped
        s_if.in_valid = 1'b1;
        s_if.in_l     = 16'h0BAD;
        s_if.in_r     = 16'h0BAD;
        mcnt--;
        data_over = 1'b1;
        step();
        check("fullpop_level", 32'(fifo_level),    7);
        check("fullpop_ready", 32'(s_if.in_ready), 1);
        s_if.in_l = 16'h3001;
        s_if.in_r = 16'h4001;
        mcnt++;
        exp_q.push_back({16'h3001, 16'h4001});
        data_over = 1'b0;
        step();
        s_if.in_valid = 1'b0;
        check("refill_level", 32'(fifo_level), 8);

        // Push and pop on the same edge while not full: level unchanged
        consume();
        check("pre_pp_level", 32'(fifo_level), 7);
        s_if.in_valid = 1'b1;
        s_if.in_l     = 16'h3002;
        s_if.in_r     = 16'h4002;
        exp_q.push_back({16'h3002, 16'h4002});
        data_over = 1'b1;
        step();
        s_if.in_valid = 1'b0;
        check("pp_level", 32'(fifo_level), 7);
        data_over = 1'b0;
        step();
        while (mcnt > 0) consume();
        check("drain_level", 32'(fifo_level), 0);

        // Underrun saturation
        for (int i = 0; i < 300; i++) consume();
        check("underrun_sat", 32'(underrun_cnt), 255);

        // RUN dropped in DONE with 3 pairs buffered
        for (int i = 0; i < 4; i++)
            push_pair(16'(16'h7000 + i), 16'(16'h7100 + i));
        mcnt--;
        data_over = 1'b1;
        step();
        check("done_level", 32'(fifo_level), 3);
        RUN = 1'b0;
        step();
        exp_q.delete();
        mcnt = 0;
        data_over = 1'b0;
        check("stop_level", 32'(fifo_level),    0);
        check("stop_INIT",  32'(INIT),          0);
        check("stop_ready", 32'(s_if.in_ready), 1);
        check("stop_LDATA", 32'(LDATA),         0);
        step();
        check("hold_stay_INIT", 32'(INIT), 0);

        // Restart, then asynchronous reset mid-WRITE
        RUN = 1'b1;
        step();
        check("restart_INIT", 32'(INIT), 1);
        INIT_FINISH = 1'b1;
        step();
        INIT_FINISH = 1'b0;
        push_pair(16'h1111, 16'h2222);
        push_pair(16'h3333, 16'h4444);
        check("pre_rst_level", 32'(fifo_level), 2);
        check("pre_rst_LDATA", 32'(LDATA),      32'h1111);
        #2;
        Reset_n = 1'b0;
        #1;
        exp_q.delete();
        mcnt = 0;
        check("arst_level",    32'(fifo_level),    0);
        check("arst_ready",    32'(s_if.in_ready), 1);
        check("arst_LDATA",    32'(LDATA),         0);
        check("arst_RDATA",    32'(RDATA),         0);
        check("arst_INIT",     32'(INIT),          0);
        check("arst_underrun", 32'(underrun_cnt),  0);
        @(negedge Clk);
        RUN     = 1'b0;
        Reset_n = 1'b1;
        step();
        step();
        check("post_rst_INIT",  32'(INIT),       0);
        check("post_rst_level", 32'(fifo_level), 0);
        check("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
